muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Consumes the same rs1/rs2 operand buses as the ALU and the instruction's funct3 (decoded by control). Its result feeds the writeback mux as an alternative to the ALU result.
- Control stalls the PC while busy is high.
- Radix-2: one partial-product or quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the unit is not busy
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand (dividend / multiplicand)
- b  input  XLEN  rs2 operand (divisor / multiplier)
- busy  output  1  high while iterating; start ignored
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  registered result; holds until the next completion
- zero  output  1  (result == 0), combinational from the result register

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, iteration count=0, internal operand/accumulator registers=0.
- Reset mid-operation abandons the operation. No done pulse follows; result reads 0.
- States:
  - IDLE: waits for start.
  - RUN: iterating.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE: start=1 at edge E0 latches a, b, op and goes to RUN (count=0). A special case instead goes directly to DONE at E0.
  - RUN: one iteration per edge. After edge E32 (XLEN iterations), the final sign fix-up is written to result and the state goes to DONE.
  - DONE: start=1 behaves as in IDLE (back-to-back accepted). Otherwise the state goes to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge E32, i.e. 32 cycles after the start edge.
  - Special case: done is high in the cycle right after E0.
- busy: 1 only in RUN. 0 in IDLE and DONE. done and busy are never high together.
- start while busy: ignored. Operand and op changes during RUN have no effect; operands are latched at E0.
- Multiply:
  - Shift-add on operand magnitudes, with signedness per op (MULH: both signed; MULHSU: a signed, b unsigned; MULHU/MUL: unsigned magnitudes).
  - 64-bit product; negated at the end if the operand signs differ (signed cases only).
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Truncation toward zero.
- Special cases (fast path, no RUN):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - Signed overflow, a=0x80000000 and b=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
  - Multiply never takes the fast path.
- zero reflects the held result at all times, including after reset (zero=1).

Test Plan:
- MUL a=7, b=6, start pulse → busy high 32 cycles, done pulse once, result=0x0000002A, zero=0.
- MULH a=0xFFFFFFFF (-1), b=0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU a=-1, b=2 → 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM same operands → 0xFFFFFFFF (-1). DIVU a=100, b=7 → 14. REMU same operands → 2.
- Fast path:
  - DIVU a=5, b=0 → done the cycle after start, result=0xFFFFFFFF, busy never 1.
  - REM a=0x80000000, b=-1 → result=0, zero=1.
- Handshake:
  - start re-asserted and operands changed during RUN → ignored; result matches the originally latched operands.
  - start asserted in the DONE cycle → a second op is accepted, and the second done comes 32 cycles later.
- rst asserted at iteration 10 of a DIV → next cycle busy=0, done=0, result=0. No done pulse follows; a subsequent MUL 3×3 completes with result=9.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, with a fast path for divide corner cases.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [AW-1:0]   acc, acc_next;
    logic [XLEN-1:0] opd, opd_next;
    logic [2:0]      op_q, op_next;
    logic            neg_q, neg_next;
    logic [XLEN-1:0] result_next;

    logic            sgn_a, sgn_b, neg_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_val;
    logic [XLEN:0]   mul_sum, div_diff;
    logic [AW-1:0]   step, prod;
    logic [XLEN-1:0] div_sel, fix_res;

    // Operand signedness, magnitudes and divide corner cases at issue
    always_comb begin
        sgn_a    = a[XLEN-1] & ((op == OP_MULH) || (op == OP_MULHSU) ||
                                (op == OP_DIV)  || (op == OP_REM));
        sgn_b    = b[XLEN-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        mag_a    = sgn_a ? -a : a;
        mag_b    = sgn_b ? -b : b;
        neg_in   = (op[2] && op[1]) ? sgn_a : (sgn_a ^ sgn_b);
        div_zero = op[2] && (b == '0);
        div_ovf  = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (div_zero) fast_val = op[1] ? a : '1;
        else          fast_val = op[1] ? '0 : a;
    end

    // One iteration plus the sign fix-up applied on the final iteration
    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + {1'b0, opd};
        div_diff = acc[AW-1:XLEN-1] - {1'b0, opd};
        if (op_q[2]) begin
            step = div_diff[XLEN] ? {acc[AW-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};
        end
        prod    = neg_q ? -step : step;
        div_sel = op_q[1] ? step[AW-1:XLEN] : step[XLEN-1:0];
        if (op_q[2])              fix_res = neg_q ? -div_sel : div_sel;
        else if (op_q == OP_MUL)  fix_res = prod[XLEN-1:0];
        else                      fix_res = prod[AW-1:XLEN];
    end

    // Next-state and datapath updates
    always_comb begin
        state_next  = state;
        count_next  = count;
        acc_next    = acc;
        opd_next    = opd;
        op_next     = op_q;
        neg_next    = neg_q;
        result_next = result;
        case (state)
            IDLE, DONE: begin
                if (state == DONE) state_next = IDLE;
                if (start) begin
                    op_next    = op;
                    neg_next   = neg_in;
                    count_next = '0;
                    if (div_zero || div_ovf) begin
                        result_next = fast_val;
                        state_next  = DONE;
                    end else begin
                        opd_next   = op[2] ? mag_b : mag_a;
                        acc_next   = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                acc_next   = step;
                count_next = count + CW'(1);
                if (count == CW'(XLEN - 1)) begin
                    result_next = fix_res;
                    state_next  = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            opd    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            acc    <= acc_next;
            opd    <= opd_next;
            op_q   <= op_next;
            neg_q  <= neg_next;
            result <= result_next;
            busy   <= (state_next == RUN);
            done   <= (state_next == DONE);
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected result and completion
// cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk, rst, start;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done, zero;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned due;
    } exp_t;
    exp_t q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = int'(x);
        iy = int'(y);
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=%h exp=no_pending_op", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("done_cycle", cyc, e.due);
                    chk("zero", {31'b0, zero}, {31'b0, e.res == 0});
                    chk("busy_with_done", {31'b0, busy}, 32'h0);
                end
            end
        end
    endtask

    // Waits for the unit to accept, then records the expected completion
    task automatic issue(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("issue_timeout", 32'(guard), 32'h0);
        start = 1'b1;
        op = f;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        e.res = model(f, x, y);
        e.due = cyc + (is_fast(f, x, y) ? 0 : 32);
        q.push_back(e);
        start = 1'b0;
    endtask

    initial begin
        int          n;
        int          guard;
        logic [2:0]  f;
        logic [31:0] x, y;

        rst = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_zero", {31'b0, zero}, 32'h1);
        rst = 1'b0;

        fork
            monitor();
        join_none

        // MUL 7x6 and count busy cycles up to the done pulse
        issue(3'd0, 32'd7, 32'd6);
        n = 0;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            guard++;
            if (done) break;
            if (busy) n++;
        end
        chk("mul_busy_cycles", 32'(n), 32'd32);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);

        // Fast paths: busy must stay low
        issue(3'd5, 32'd5, 32'd0);
        @(negedge clk);
        chk("fast_busy", {31'b0, busy}, 32'h0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h1234_5678, 32'd0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);

        // start and operand changes during RUN are ignored
        issue(3'd0, 32'd123456, 32'd789);
        repeat (5) begin
            @(negedge clk);
            start = 1'b1;
            op = 3'd4;
            a = $urandom;
            b = 32'd0;
        end
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: second op accepted in the DONE cycle
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd6, 32'h7FFF_FFFF, 32'hFFFF_FFF0);

        // Reset mid-divide abandons the operation
        issue(3'd4, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd3);

        // Randomised ops with corner-value operands and random gaps
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       y = 32'h0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 15));
                default: y = 32'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(f, x, y);
        end

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
